// File: rtl/apb_slv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : apb_slv_pkg
//  Description : Shared types and helpers for the parametrised APB memory
//                slave: FSM state enum, latched transfer context and the
//                address error decode.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_slv_pkg;

  // Context fields are sized for the widest supported bus.
  // Narrower configurations zero-extend into them.
  localparam int unsigned CTX_ADDR_W = 64;
  localparam int unsigned CTX_DATA_W = 64;
  localparam int unsigned CTX_STRB_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  typedef struct packed {
    logic [CTX_ADDR_W-1:0] addr;
    logic                  write;
    logic [CTX_DATA_W-1:0] wdata;
    logic [CTX_STRB_W-1:0] strb;
    logic                  err;
  } apb_ctx_t;

  // An address is in error when it is not word aligned.
  // It is also in error when its word index is at or beyond the memory depth.
  function automatic logic addr_err(input logic [CTX_ADDR_W-1:0] addr,
                                    input int unsigned           depth,
                                    input int unsigned           lsb);
    logic [CTX_ADDR_W-1:0] lsb_mask;
    logic [CTX_ADDR_W-1:0] idx;
    lsb_mask = (CTX_ADDR_W'(1) << lsb) - CTX_ADDR_W'(1);
    idx      = addr >> lsb;
    return ((addr & lsb_mask) != '0) || (idx >= CTX_ADDR_W'(depth));
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slv_mem.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slv_mem
//  Description : DEPTH x DATA_W register array with asynchronous clear,
//                byte-enabled write port and combinational read port.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_slv_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, byte lanes written where their strobe is set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < int'(DEPTH); w++) begin
        mem_q[w] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/apb_mem_slave_p.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_slave_p
//  Description : Parametrised APB3/APB4 memory slave with fixed wait states
//                and PSLVERR on misaligned or out-of-range accesses.
//                Define APB_SLV_PSTRB_EN to add the PSTRB byte-strobe port.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_mem_slave_p
  import apb_slv_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic                PWRITE,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  apb_state_e        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  apb_ctx_t          ctx_q, ctx_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic              w_err_in;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [STRB_W-1:0] w_strb_in;
  logic [DATA_W-1:0] w_rdata;
  logic              w_mem_we;

`ifdef APB_SLV_PSTRB_EN
  assign w_strb_in = PSTRB;
`else
  assign w_strb_in = '1;
`endif

  // The read index comes from the live bus, because read data is captured at the setup edge.
  // The write index comes from the latched context.
  assign w_err_in = addr_err(CTX_ADDR_W'(PADDR), DEPTH, LSB);
  assign w_rd_idx = IDX_W'(PADDR >> LSB);
  assign w_wr_idx = IDX_W'(ctx_q.addr >> LSB);

  apb_slv_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .we_i    (w_mem_we),
    .waddr_i (w_wr_idx),
    .wdata_i (DATA_W'(ctx_q.wdata)),
    .wstrb_i (STRB_W'(ctx_q.strb)),
    .raddr_i (w_rd_idx),
    .rdata_o (w_rdata)
  );

  // State, wait counter, latched context and read data registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      ctx_q    <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ctx_q    <= ctx_d;
      prdata_q <= prdata_d;
    end
  end

  // Next-state logic: setup capture, wait countdown, completion and abort
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ctx_d    = ctx_q;
    prdata_d = prdata_q;
    w_mem_we = 1'b0;
    case (state_q)
      IDLE: begin
        // PSEL with PENABLE already high is a protocol violation and is ignored
        if (PSEL && !PENABLE) begin
          ctx_d.addr  = CTX_ADDR_W'(PADDR);
          ctx_d.write = PWRITE;
          ctx_d.wdata = CTX_DATA_W'(PWDATA);
          ctx_d.strb  = CTX_STRB_W'(w_strb_in);
          ctx_d.err   = w_err_in;
          wcnt_d      = 4'(WAIT_STATES);
          if (!PWRITE) begin
            prdata_d = w_err_in ? '0 : w_rdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (PENABLE) begin
          w_mem_we = ctx_q.write & ~ctx_q.err;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PREADY  = (state_q == ACCESS) && (wcnt_q == 4'd0);
  assign PSLVERR = PREADY & ctx_q.err;
  assign PRDATA  = prdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_mem_slave_p
//  Description : Self-checking bench for apb_mem_slave_p (directed plus
//                randomized transfers against a word-array reference model).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_mem_slave_p;

  localparam int DEPTH = 32;
  localparam int WS    = 2;

  logic        PCLK = 1'b0;
  logic        rst_n;
  logic        psel, psel_z, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata, prdata_z;
  logic        pready, pready_z, pslverr, pslverr_z;

  int tests = 0;
  int fails = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  always #5 PCLK = ~PCLK;

  apb_mem_slave_p #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .PCLK    (PCLK),
    .PRESETn (rst_n),
    .PSEL    (psel),
    .PENABLE (penable),
    .PADDR   (paddr),
    .PWRITE  (pwrite),
    .PWDATA  (pwdata),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB   (pstrb),
`endif
    .PRDATA  (prdata),
    .PREADY  (pready),
    .PSLVERR (pslverr)
  );

  apb_mem_slave_p #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_z (
    .PCLK    (PCLK),
    .PRESETn (rst_n),
    .PSEL    (psel_z),
    .PENABLE (penable),
    .PADDR   (paddr),
    .PWRITE  (pwrite),
    .PWDATA  (pwdata),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB   (pstrb),
`endif
    .PRDATA  (prdata_z),
    .PREADY  (pready_z),
    .PSLVERR (pslverr_z)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rules: byte address, 4-byte words, DEPTH words
  function automatic bit m_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [3:0] m_strb(input logic [3:0] s);
`ifdef APB_SLV_PSTRB_EN
    return s;
`else
    return 4'hF;
`endif
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    last_rd = 32'h0;
  endtask

  // One APB transfer; PSEL/PENABLE are left high so the next call is back-to-back
  task automatic xfer(input bit z, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int cyc);
    @(negedge PCLK);
    if (z) psel_z = 1'b1; else psel = 1'b1;
    penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd; pstrb = st;
    cyc = 1;
    @(negedge PCLK);
    penable = 1'b1; cyc = 2;
    paddr = $urandom; pwdata = $urandom;
    while (!(z ? pready_z : pready) && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
    end
    if (!(z ? pready_z : pready)) check("pready timeout", 64'(pready), 64'd1);
    rd  = z ? prdata_z : prdata;
    err = z ? pslverr_z : pslverr;
  endtask

  task automatic idle();
    @(negedge PCLK);
    psel = 1'b0; psel_z = 1'b0; penable = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input string tag);
    logic [31:0] rd; logic err; int cyc;
    xfer(1'b0, a, 1'b1, d, s, rd, err, cyc);
    check({tag, " wr pslverr"}, 64'(err), 64'(m_err(a)));
    check({tag, " wr cycles"}, 64'(cyc), 64'(2 + WS));
    check({tag, " wr prdata hold"}, 64'(rd), 64'(last_rd));
    if (!m_err(a)) model[a / 4] = m_merge(model[a / 4], d, m_strb(s));
  endtask

  task automatic do_rd(input logic [31:0] a, input string tag);
    logic [31:0] rd; logic err; int cyc; logic [31:0] exp;
    exp = m_err(a) ? 32'h0 : model[a / 4];
    xfer(1'b0, a, 1'b0, $urandom, $urandom, rd, err, cyc);
    check({tag, " rd data"}, 64'(rd), 64'(exp));
    check({tag, " rd pslverr"}, 64'(err), 64'(m_err(a)));
    check({tag, " rd cycles"}, 64'(cyc), 64'(2 + WS));
    last_rd = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic err; int cyc;
    logic [31:0] a, d; logic [3:0] s; bit wr;
    rst_n = 1'b0; psel = 1'b0; psel_z = 1'b0; penable = 1'b0;
    paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
    model_clear();
    repeat (3) @(negedge PCLK);
    check("reset pready", 64'(pready), 64'd0);
    check("reset pslverr", 64'(pslverr), 64'd0);
    check("reset prdata", 64'(prdata), 64'd0);
    rst_n = 1'b1;

    // Fresh memory reads zero; PREADY low for two ACCESS cycles
    do_rd(32'h04, "t1");
    idle();

    // Write then read back
    do_wr(32'h10, 32'hDEADBEEF, 4'hF, "t2");
    do_rd(32'h10, "t2");
    check("t2 literal", 64'(prdata), 64'h0000_0000_DEAD_BEEF);
    idle();

    // Zero wait states: back-to-back transfers take two cycles each
    xfer(1'b1, 32'h20, 1'b1, 32'hA5A5_1234, 4'hF, rd, err, cyc);
    check("t2z wr cycles", 64'(cyc), 64'd2);
    xfer(1'b1, 32'h20, 1'b0, 32'h0, 4'hF, rd, err, cyc);
    check("t2z rd cycles", 64'(cyc), 64'd2);
    check("t2z rd data", 64'(rd), 64'hA5A5_1234);
    check("t2z rd pslverr", 64'(err), 64'd0);
    idle();

    // Range and alignment errors must not write
    do_wr(32'h80, 32'h1, 4'hF, "t3 range");
    do_wr(32'h06, 32'h1, 4'hF, "t3 align");
    do_rd(32'h00, "t3");
    do_rd(32'h04, "t3");
    idle();

    // Abort after one wait cycle
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h55; pstrb = 4'hF;
    @(negedge PCLK); penable = 1'b1;
    @(negedge PCLK); psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    check("t4 abort pready", 64'(pready), 64'd0);
    do_rd(32'h08, "t4");
    idle();

    // Reset during the ACCESS phase of a write
    do_rd(32'h10, "t5 pre");
    idle();
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h77; pstrb = 4'hF;
    @(negedge PCLK); penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t5 rst pready", 64'(pready), 64'd0);
    check("t5 rst pslverr", 64'(pslverr), 64'd0);
    check("t5 rst prdata", 64'(prdata), 64'd0);
    model_clear();
    @(negedge PCLK);
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    do_rd(32'h0C, "t5");
    do_rd(32'h10, "t5 cleared");
    idle();

    // Byte strobes
    do_wr(32'h14, 32'hDEADBEEF, 4'hF, "t6");
    do_wr(32'h14, 32'h12345678, 4'b0011, "t6");
    do_rd(32'h14, "t6");
`ifdef APB_SLV_PSTRB_EN
    check("t6 literal", 64'(prdata), 64'h0000_0000_DEAD_5678);
`else
    check("t6 literal", 64'(prdata), 64'h0000_0000_1234_5678);
`endif
    do_wr(32'h14, 32'hFFFFFFFF, 4'b0000, "t6 nostrb");
    do_rd(32'h14, "t6 nostrb");
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: a = {25'd0, 5'($urandom_range(0, DEPTH - 1)), 2'b00};
        3:       a = {25'd0, 5'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        default: a = 32'($urandom_range(DEPTH * 4, 32'hFFFF_FFFC)) & 32'hFFFF_FFFC;
      endcase
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      if (wr) do_wr(a, d, s, "rand");
      else    do_rd(a, "rand");
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge PCLK);
        check("rand idle prdata hold", 64'(prdata), 64'(last_rd));
        check("rand idle pready", 64'(pready), 64'd0);
      end
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
